// File: rtl/an_sec_decoder_serial.sv
// Serial single-error-correcting decoder for AN arithmetic codes.
// Computes the codeword residue mod A bit-serially, then searches the +/-2^k residues for the error.
module an_sec_decoder_serial #(
    parameter int unsigned A    = 67,
    parameter int unsigned N    = 34,
    parameter int unsigned KMAX = 33,
    parameter int unsigned RW   = $clog2(A),
    parameter int unsigned PW   = (KMAX > 1) ? $clog2(KMAX) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_cw,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [N:0]    out_awe,
    output logic [PW-1:0] out_pos,
    output logic [RW-1:0] out_rem,
    output logic          out_corr,
    output logic          out_uncorr
);

    localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW:0] A_EXT = (RW+1)'(A);

    typedef enum logic [1:0] {IDLE, REM, SEARCH, DONE} state_t;

    state_t        state;
    logic [N-1:0]  cw;
    logic [RW-1:0] rem;
    logic [RW-1:0] s;
    logic [IW-1:0] idx;
    logic [PW-1:0] k;

    logic [RW:0]   rem_dbl;
    logic [RW:0]   s_dbl;
    logic [RW:0]   s_neg;
    logic [RW-1:0] rem_nxt;
    logic [RW-1:0] s_nxt;
    logic [N:0]    awe_pos;
    logic [N:0]    awe_neg;

    // Doubling steps stay below 2A, so one conditional subtract reduces them.
    assign rem_dbl = {rem, cw[idx]};
    assign rem_nxt = (rem_dbl >= A_EXT) ? RW'(rem_dbl - A_EXT) : RW'(rem_dbl);
    assign s_dbl   = {s, 1'b0};
    assign s_nxt   = (s_dbl >= A_EXT) ? RW'(s_dbl - A_EXT) : RW'(s_dbl);
    assign s_neg   = A_EXT - {1'b0, s};
    assign awe_pos = (N+1)'(1) << k;
    assign awe_neg = (N+1)'(0) - awe_pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_awe    <= '0;
            out_pos    <= '0;
            out_rem    <= '0;
            out_corr   <= 1'b0;
            out_uncorr <= 1'b0;
            cw         <= '0;
            rem        <= '0;
            s          <= '0;
            idx        <= '0;
            k          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cw       <= in_cw;
                        rem      <= '0;
                        idx      <= IW'(N - 1);
                        in_ready <= 1'b0;
                        state    <= REM;
                    end
                end
                REM: begin
                    rem <= rem_nxt;
                    idx <= idx - IW'(1);
                    if (idx == '0) begin
                        if (rem_nxt == '0) begin
                            out_data   <= cw;
                            out_awe    <= '0;
                            out_pos    <= '0;
                            out_rem    <= rem_nxt;
                            out_corr   <= 1'b0;
                            out_uncorr <= 1'b0;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            s     <= RW'(1);
                            k     <= '0;
                            state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    // Lowest k wins; the + form is checked before the - form.
                    if (rem == s) begin
                        out_data   <= cw - awe_pos[N-1:0];
                        out_awe    <= awe_pos;
                        out_pos    <= k;
                        out_rem    <= rem;
                        out_corr   <= 1'b1;
                        out_uncorr <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else if ({1'b0, rem} == s_neg) begin
                        out_data   <= cw - awe_neg[N-1:0];
                        out_awe    <= awe_neg;
                        out_pos    <= k;
                        out_rem    <= rem;
                        out_corr   <= 1'b1;
                        out_uncorr <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else if (k == PW'(KMAX - 1)) begin
                        out_data   <= cw;
                        out_awe    <= '0;
                        out_pos    <= '0;
                        out_rem    <= rem;
                        out_corr   <= 1'b0;
                        out_uncorr <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        s <= s_nxt;
                        k <= k + PW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/an_sec_decoder_serial.md
# an_sec_decoder_serial

Parametrised, multi-cycle single-error-correcting decoder for AN (product) arithmetic codes. It replaces fixed-modulus residue lookup tables with two serial engines:

- a bit-serial residue engine that computes the received codeword mod A;
- an iterative search over ±2^k residues that recovers the arithmetic weight error (AWE).

It then subtracts the AWE from the codeword. It sits between the AN-coded datapath output and the downstream divide-by-A/data-extract stage, using valid/ready handshakes on both sides.

## Interface
Parameters:
- A, 67, odd code modulus; must not be a power of two.
- N, 34, codeword width in bits (unsigned).
- KMAX, 33, number of error bit positions searched (positions 0..KMAX-1); 1 ≤ KMAX ≤ N.
- RW, $clog2(A), residue width.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  codeword offered.
- in_ready  output  1  block idle and able to accept.
- in_cw  input  N  received codeword.
- out_valid  output  1  result held.
- out_ready  input  1  downstream accepts the result.
- out_data  output  N  corrected codeword, (in_cw − AWE) mod 2^N.
- out_awe  output  N+1  signed AWE: +2^k, −2^k or 0.
- out_pos  output  $clog2(KMAX)  error bit position k; 0 when no error is found.
- out_rem  output  RW  residue of in_cw mod A.
- out_corr  output  1  a single error was found and corrected.
- out_uncorr  output  1  residue is nonzero but no ±2^k match was found within KMAX positions.

## Operation
The block uses four states: IDLE, REM, SEARCH, DONE. in_ready is 1 only in IDLE. out_valid is 1 only in DONE.

- **IDLE**
  - On an edge with in_valid=1: latch in_cw into a held register (never modified).
  - Set rem=0 and bit index i=N−1, then go to REM.
- **REM**, one bit per edge, MSB first:
  - rem ← (2·rem + cw[i]) mod A, computed as a single conditional subtract of A (the intermediate value is always < 2A).
  - Decrement i.
  - On the N-th REM edge, evaluate the new residue:
    - If it is 0: go to DONE with awe=0, corr=0, uncorr=0.
    - Otherwise: go to SEARCH with s=1, k=0.
- **SEARCH**, one position per edge. Checks are made in this priority order:
  1. rem==s: DONE, awe=+2^k, pos=k, corr=1.
  2. rem==A−s: DONE, awe=−2^k, pos=k, corr=1.
  3. k==KMAX−1: DONE, awe=0, pos=0, uncorr=1.
  4. Otherwise: s ← (2s) mod A by conditional subtract, k ← k+1.
- **DONE**
  - Every output is held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
- **Arithmetic rules**
  - out_data = cw − sign-extended out_awe, truncated to N bits. Wrap-around modulo 2^N is the intended behaviour.
  - When uncorr=1, out_data=cw unchanged.
  - out_rem holds the final residue in every DONE case.
- **Ambiguity**
  - If a residue matches both +2^k and −2^k forms at different k (possible when KMAX exceeds half the order of 2 mod A), the lowest k wins, with + checked before − at equal k.
  - For A=67 and KMAX=33 every nonzero residue maps to exactly one AWE.
- **Reset**
  - rst=1 at any time, including mid-REM or mid-SEARCH, forces IDLE immediately.
  - The in-flight codeword is discarded and no out_valid pulse is produced.

## Timing
- **Reset values:**
  - state=IDLE, in_ready=1, out_valid=0;
  - out_data, out_awe, out_pos, out_rem = 0;
  - out_corr=0, out_uncorr=0.
- **Latency,** counted as edges from the accept edge to the edge that raises out_valid:
  - clean codeword: N;
  - error at position k: N+k+1;
  - uncorrectable: N+KMAX.
- **Output registers:** all outputs are registers, updated only on the edge that enters DONE.
- **Throughput:** one codeword per (latency + 1 handshake edge) minimum.
- **Input handshake:** in_valid is ignored outside IDLE; in_cw is sampled only on the accept edge.
- **Back-to-back:** when out_ready=1 in the first DONE cycle, DONE lasts exactly one cycle and in_ready rises the following cycle.

## Test plan
All scenarios use A=67, N=34, KMAX=33 unless stated otherwise.
- **Clean codeword:** in_cw=335 (67·5) -> out_rem=0, out_awe=0, out_data=335, corr=0, uncorr=0; out_valid 34 edges after accept.
- **Positive error:** in_cw=463 (335+2^7) -> out_rem=61, out_awe=+128, out_pos=7, out_data=335, corr=1; latency 42.
- **Negative error at bit 0:** in_cw=334 -> out_rem=66, out_awe=−1, out_pos=0, out_data=335; latency 35.
- **Top position:** in_cw=335+2^32 -> out_rem=33, out_awe=+2^32, out_pos=32, out_data=335; latency 67.
- **Uncorrectable:** instance with KMAX=16, same codeword 335+2^32 -> out_uncorr=1, out_data=in_cw, out_awe=0; latency 50.
- **Backpressure and reset:**
  - Hold out_ready=0 for 10 cycles in DONE: outputs stay stable, in_ready stays 0, and a new in_valid is ignored.
  - Separately, assert rst mid-SEARCH: next cycle in_ready=1, out_valid=0, all outputs 0; a fresh codeword 335 then decodes normally.
